// File: rtl/bcd_stopwatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_ctrl_pkg
// Brief    : Shared types, digit constants and helpers for the BCD stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   // True when the low n nibbles of v all hold 9 (n is at most 8).
   function automatic logic all_nines(input logic [31:0] v, input int n);
      logic r;
      r = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i < n && v[4*i +: 4] != BCD_MAX) r = 1'b0;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_ctrl_if
// Brief    : Command pulses in, display value and status out.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_stopwatch_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                start;
   logic                stop;
   logic                clear;
   logic                lap;
   logic [4*DIGITS-1:0] bcd;
   logic                running;
   logic                overflow;
   logic                lap_hold;

   modport master (
      output start, stop, clear, lap,
      input  bcd, running, overflow, lap_hold
   );

   modport slave (
      input  start, stop, clear, lap,
      output bcd, running, overflow, lap_hold
   );
endinterface
`default_nettype wire

// File: rtl/bcd_stopwatch_ctrl_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Brief    : One decade digit; wraps 9 (or any illegal code) back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
   import bcd_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       is_nine
);
   logic [3:0] r_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= BCD_ZERO;
      end else if (clr) begin
         r_q <= BCD_ZERO;
      end else if (inc) begin
         r_q <= (r_q >= BCD_MAX) ? BCD_ZERO : r_q + 4'd1;
      end
   end

   assign q       = r_q;
   assign is_nine = (r_q == BCD_MAX);
endmodule
`default_nettype wire

// File: rtl/bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_ctrl
// Brief    : Run/pause/clear sequencer, tick prescaler and cascaded BCD count.
//            Define LAP_EN to build the lap-hold display register.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_ctrl
   import bcd_ctrl_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 10
)(
   input  logic                      clk,
   input  logic                      reset,
   bcd_stopwatch_ctrl_if.slave       sw
);
   localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   C_PS_LAST  = PW'(PRESCALE - 1);

   state_t              r_state;
   logic                r_running;
   logic                r_overflow;
   logic [PW-1:0]       r_presc;
   logic [4*DIGITS-1:0] w_digits;
   logic [DIGITS-1:0]   w_nine;
   logic [DIGITS:0]     w_chain;
   logic                w_start;
   logic                w_tick;
   logic                w_all9;
   logic                w_adv;
   logic                w_ovf;

   // clear beats stop beats start
   assign w_start = sw.start & ~sw.stop & ~sw.clear;
   assign w_tick  = (r_state == RUN) & (r_presc == C_PS_LAST) & ~sw.stop & ~sw.clear;
   assign w_all9  = all_nines(32'(w_digits), DIGITS);
   assign w_adv   = w_tick & ~w_all9;
   assign w_ovf   = w_tick & w_chain[DIGITS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
      end else if (sw.clear) begin
         r_presc <= '0;
      end else if (r_state == RUN && !sw.stop) begin
         r_presc <= (r_presc == C_PS_LAST) ? '0 : r_presc + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_running  <= 1'b0;
         r_overflow <= 1'b0;
      end else if (sw.clear) begin
         r_state    <= IDLE;
         r_running  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE, PAUSE: begin
               if (w_start) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
            end
            RUN: begin
               if (sw.stop) begin
                  r_state   <= PAUSE;
                  r_running <= 1'b0;
               end else if (w_ovf) begin
                  r_state    <= HALT;
                  r_running  <= 1'b0;
                  r_overflow <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // w_chain[i] is high when every digit below i holds 9
   assign w_chain[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk     (clk),
         .reset   (reset),
         .clr     (sw.clear),
         .inc     (w_adv & w_chain[i]),
         .q       (w_digits[4*i +: 4]),
         .is_nine (w_nine[i])
      );
      assign w_chain[i+1] = w_chain[i] & w_nine[i];
   end

`ifdef LAP_EN
   logic [4*DIGITS-1:0] r_lap;
   logic                r_lap_hold;

   // Snapshot takes the pre-increment digits of the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lap      <= '0;
         r_lap_hold <= 1'b0;
      end else if (sw.clear) begin
         r_lap_hold <= 1'b0;
      end else if (sw.lap) begin
         if (!r_lap_hold) begin
            r_lap      <= w_digits;
            r_lap_hold <= 1'b1;
         end else begin
            r_lap_hold <= 1'b0;
         end
      end
   end

   assign sw.bcd      = r_lap_hold ? r_lap : w_digits;
   assign sw.lap_hold = r_lap_hold;
`else
   assign sw.bcd      = w_digits;
   assign sw.lap_hold = 1'b0;
`endif

   assign sw.running  = r_running;
   assign sw.overflow = r_overflow;
endmodule
`default_nettype wire

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
Sequencing controller for a cascaded multi-digit BCD decade counter. It owns the run/pause/clear state machine and a clock prescaler that generates count ticks. It ripples carries digit to digit and exposes a live or lap-frozen BCD display value. It sits between user push-button pulses and the seven-segment display path.

Parameters:
DIGITS, 4, number of cascaded decade digits (1..8)
PRESCALE, 10, clk cycles per count tick (>=1); prescaler width is clog2(PRESCALE), minimum 1

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (reset=0 resets the block)
start  input  1  single-cycle pulse: begin or resume counting
stop  input  1  single-cycle pulse: pause counting
clear  input  1  single-cycle pulse: zero the count, return to IDLE
lap  input  1  single-cycle pulse: toggle lap-hold of the display
bcd  output  4*DIGITS  display value; digit i is bcd[4i+3:4i], digit 0 is the least significant
running  output  1  1 while in RUN
overflow  output  1  sticky; set on rollover from all-9s
lap_hold  output  1  1 while the display is frozen

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all digits=0, prescaler=0, lap register=0, bcd=0, running=0, overflow=0, lap_hold=0.
- States:
  - IDLE: count held at 0.
  - RUN: prescaler advances.
  - PAUSE: count and prescaler held.
  - HALT: count frozen at all-9s after overflow.
- Command priority when pulses coincide: clear > stop > start. lap is independent and is processed in the same cycle as the others.
- Transitions:
  - IDLE/PAUSE + start -> RUN.
  - RUN + stop -> PAUSE.
  - Any state + clear -> IDLE, with digits=0, prescaler=0, overflow=0, lap_hold=0.
  - start in RUN or HALT is ignored. stop in IDLE, PAUSE or HALT is ignored.
- Prescaler:
  - Counts only in RUN.
  - tick = (prescaler==PRESCALE-1) while in RUN. On a tick the prescaler wraps to 0.
  - The prescaler is NOT reset by pause/resume; the partial interval is retained. It is reset only by clear or reset.
- Counting: first increment occurs on the PRESCALE-th posedge after the edge that samples start (entry to RUN counts as edge 0).
- Digit update on tick:
  - Digit 0 increments.
  - Digit i increments when digits 0..i-1 are all 9.
  - A digit at 9 that increments wraps to 0.
  - Digit values 10-15 are unreachable; if forced, the next increment takes the digit to 0.
- Overflow:
  - A tick with all digits = 9 does not wrap. Instead, state -> HALT, digits stay all-9s, overflow=1, running=0.
  - Only clear or reset leaves HALT.
- stop and tick on the same cycle: stop wins; no increment; the prescaler holds its value.
- running is registered and equals (state==RUN).
- bcd: when lap_hold=0 it shows the live digits (same cycle as the digit register). When lap_hold=1 it shows the lap register.
- Reset asserted mid-count: asynchronous return to the reset values above. The first start after reset deassertion behaves as from IDLE.

Optional Feature:
LAP_EN
- Defined:
  - A lap pulse with lap_hold=0 copies the live digits into the lap register (the value before any same-cycle increment) and sets lap_hold=1.
  - A lap pulse with lap_hold=1 clears lap_hold.
  - Counting continues underneath. lap is accepted in any state; clear overrides it.
- Undefined: lap is ignored, no lap register is built, lap_hold is tied 0, and bcd always shows the live digits.

Decomposition:
- Package bcd_ctrl_pkg:
  - State enum: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, HALT=2'd3.
  - BCD_MAX=4'd9, BCD_ZERO=4'd0.
  - Function all_nines(vector).
- Sub-module bcd_digit: one decade digit register with inputs clk, reset, clr, inc and outputs q[3:0], is_nine. DIGITS instances are generated. Carry enable is formed in the controller from the is_nine chain.

Test Plan:
1. DIGITS=4, PRESCALE=2: reset release, start pulse -> running=1 next cycle; bcd=0x0001 after 2 clks, 0x0010 after 20 clks.
2. Run to 0x0099, stop pulse -> bcd holds 0x0099 for 50 clks; start -> 0x0100 after the remaining prescale interval only (retained phase).
3. DIGITS=2, PRESCALE=1: run from 0 -> bcd=0x99 after 99 clks; next tick -> HALT, overflow=1, running=0, bcd stays 0x99; start ignored; clear -> bcd=0x00, overflow=0, state IDLE.
4. stop, start and clear pulsed together in RUN at 0x0042 -> IDLE, bcd=0x0000; stop+start together -> PAUSE.
5. LAP_EN: lap at live 0x0123 -> lap_hold=1, bcd=0x0123 while live advances to 0x0130; second lap -> bcd=0x0130 live. Without LAP_EN: same stimulus -> lap_hold=0, bcd always live.
6. Drive reset=0 asynchronously mid-RUN at 0x0057 (between clk edges) -> all outputs 0 immediately; after release, start -> count resumes from 0x0000.
